dc_queue: RTL

Buffered RV32I decode stage between the instruction fetcher and the dispatcher. Each raw 32-bit instruction accepted from the fetcher is decoded into the core's internal 7-bit opcode, register fields and a fully sign-extended immediate. The decoded record is then held in a parametrised FIFO until the dispatcher pops it. Compared with the previous pass-through decoder, this block adds:
- buffering and back-pressure to the fetcher
- flush support
- illegal-instruction flagging
- correct immediates for JALR, SRLI and sign-extended formats

---
 rtl/dc_pkg.sv | 74 +++++++
 rtl/dc_queue_if.sv | 40 ++++
 rtl/rv32i_decode.sv | 158 +++++++++++++++
 rtl/dc_queue.sv | 108 ++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// ---------------------------------------------------------------------------
// dc_pkg
// Shared definitions for the buffered RV32I decode stage.
//   - internal 7-bit opcode encoding (OP_NONE = 0, OP_LUI = 1 ... OP_AND = 37)
//   - RV32I major-opcode constants (inst[6:0])
//   - entry_t: one decoded record as stored in the decode FIFO
// ---------------------------------------------------------------------------
package dc_pkg;

  localparam int unsigned DC_ADDR_WIDTH = 32;
  localparam int unsigned DC_REG_WIDTH  = 5;

  // Internal opcode encoding shared with the dispatcher
  localparam logic [6:0] OP_NONE  = 7'd0;
  localparam logic [6:0] OP_LUI   = 7'd1;
  localparam logic [6:0] OP_AUIPC = 7'd2;
  localparam logic [6:0] OP_JAL   = 7'd3;
  localparam logic [6:0] OP_JALR  = 7'd4;
  localparam logic [6:0] OP_BEQ   = 7'd5;
  localparam logic [6:0] OP_BNE   = 7'd6;
  localparam logic [6:0] OP_BLT   = 7'd7;
  localparam logic [6:0] OP_BGE   = 7'd8;
  localparam logic [6:0] OP_BLTU  = 7'd9;
  localparam logic [6:0] OP_BGEU  = 7'd10;
  localparam logic [6:0] OP_LB    = 7'd11;
  localparam logic [6:0] OP_LH    = 7'd12;
  localparam logic [6:0] OP_LW    = 7'd13;
  localparam logic [6:0] OP_LBU   = 7'd14;
  localparam logic [6:0] OP_LHU   = 7'd15;
  localparam logic [6:0] OP_SB    = 7'd16;
  localparam logic [6:0] OP_SH    = 7'd17;
  localparam logic [6:0] OP_SW    = 7'd18;
  localparam logic [6:0] OP_ADDI  = 7'd19;
  localparam logic [6:0] OP_SLTI  = 7'd20;
  localparam logic [6:0] OP_SLTIU = 7'd21;
  localparam logic [6:0] OP_XORI  = 7'd22;
  localparam logic [6:0] OP_ORI   = 7'd23;
  localparam logic [6:0] OP_ANDI  = 7'd24;
  localparam logic [6:0] OP_SLLI  = 7'd25;
  localparam logic [6:0] OP_SRLI  = 7'd26;
  localparam logic [6:0] OP_SRAI  = 7'd27;
  localparam logic [6:0] OP_ADD   = 7'd28;
  localparam logic [6:0] OP_SUB   = 7'd29;
  localparam logic [6:0] OP_SLL   = 7'd30;
  localparam logic [6:0] OP_SLT   = 7'd31;
  localparam logic [6:0] OP_SLTU  = 7'd32;
  localparam logic [6:0] OP_XOR   = 7'd33;
  localparam logic [6:0] OP_SRL   = 7'd34;
  localparam logic [6:0] OP_SRA   = 7'd35;
  localparam logic [6:0] OP_OR    = 7'd36;
  localparam logic [6:0] OP_AND   = 7'd37;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] MAJ_LUI    = 7'b0110111;
  localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;
  localparam logic [6:0] MAJ_JAL    = 7'b1101111;
  localparam logic [6:0] MAJ_JALR   = 7'b1100111;
  localparam logic [6:0] MAJ_BRANCH = 7'b1100011;
  localparam logic [6:0] MAJ_LOAD   = 7'b0000011;
  localparam logic [6:0] MAJ_STORE  = 7'b0100011;
  localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;
  localparam logic [6:0] MAJ_OP     = 7'b0110011;

  typedef struct packed {
    logic [DC_ADDR_WIDTH-1:0] pc;
    logic [6:0]               opcode;
    logic [DC_REG_WIDTH-1:0]  rs1;
    logic [DC_REG_WIDTH-1:0]  rs2;
    logic [DC_REG_WIDTH-1:0]  rd;
    logic [31:0]              imm;
    logic                     illegal;
  } entry_t;

endpackage

// File: rtl/dc_queue_if.sv
// ---------------------------------------------------------------------------
// dc_queue_if
// Fetcher-side and dispatcher-side handshake bundle of the decode queue.
//   master : the decode queue (consumes IF2DC_*, DP2DC_query_inst;
//            drives DC2IF_full and DC2DP_*)
//   slave  : the surrounding fetcher/dispatcher environment
// ---------------------------------------------------------------------------
interface dc_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 5
);

  logic                  IF2DC_en;
  logic [ADDR_WIDTH-1:0] IF2DC_pc;
  logic [31:0]           IF2DC_inst;
  logic                  DC2IF_full;

  logic                  DP2DC_query_inst;
  logic                  DC2DP_en;
  logic [ADDR_WIDTH-1:0] DC2DP_pc;
  logic [6:0]            DC2DP_opcode;
  logic [REG_WIDTH-1:0]  DC2DP_rs1;
  logic [REG_WIDTH-1:0]  DC2DP_rs2;
  logic [REG_WIDTH-1:0]  DC2DP_rd;
  logic [31:0]           DC2DP_imm;
  logic                  DC2DP_illegal;

  modport master (
    input  IF2DC_en, IF2DC_pc, IF2DC_inst, DP2DC_query_inst,
    output DC2IF_full, DC2DP_en, DC2DP_pc, DC2DP_opcode,
           DC2DP_rs1, DC2DP_rs2, DC2DP_rd, DC2DP_imm, DC2DP_illegal
  );

  modport slave (
    output IF2DC_en, IF2DC_pc, IF2DC_inst, DP2DC_query_inst,
    input  DC2IF_full, DC2DP_en, DC2DP_pc, DC2DP_opcode,
           DC2DP_rs1, DC2DP_rs2, DC2DP_rd, DC2DP_imm, DC2DP_illegal
  );

endinterface

// File: rtl/rv32i_decode.sv
// ---------------------------------------------------------------------------
// rv32i_decode
// Purely combinational RV32I decoder: raw instruction -> decoded entry.
//   pc_in     : PC of the instruction, copied into the record
//   inst_in   : raw 32-bit instruction word
//   entry_out : internal opcode, register fields, sign-extended immediate,
//               illegal flag
// Fields a format does not use are forced to zero so the dispatcher never
// sees stale register indices. Illegal encodings report opcode 0 and imm 0.
// ---------------------------------------------------------------------------
module rv32i_decode
  import dc_pkg::*;
(
  input  logic [DC_ADDR_WIDTH-1:0] pc_in,
  input  logic [31:0]              inst_in,
  output entry_t                   entry_out
);

  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic [6:0]  opcode;
  logic [31:0] imm;
  logic        illegal;
  logic        use_rs1, use_rs2, use_rd;

  assign funct3 = inst_in[14:12];
  assign imm_i  = {{20{inst_in[31]}}, inst_in[31:20]};
  assign imm_s  = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b  = {{19{inst_in[31]}}, inst_in[31], inst_in[7],
                   inst_in[30:25], inst_in[11:8], 1'b0};
  assign imm_j  = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12],
                   inst_in[20], inst_in[30:21], 1'b0};
  assign imm_u  = {inst_in[31:12], 12'b0};
  assign imm_sh = {27'b0, inst_in[24:20]};

  // Opcode/immediate selection per major opcode; register-use flags decide
  // which index fields survive into the record.
  always_comb begin
    opcode  = OP_NONE;
    imm     = '0;
    illegal = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    use_rd  = 1'b1;
    case (inst_in[6:0])
      MAJ_LUI: begin
        opcode  = OP_LUI;
        imm     = imm_u;
        use_rs1 = 1'b0;
      end
      MAJ_AUIPC: begin
        opcode  = OP_AUIPC;
        imm     = imm_u;
        use_rs1 = 1'b0;
      end
      MAJ_JAL: begin
        opcode  = OP_JAL;
        imm     = imm_j;
        use_rs1 = 1'b0;
      end
      MAJ_JALR: begin
        opcode = OP_JALR;
        imm    = imm_i;
      end
      MAJ_BRANCH: begin
        imm     = imm_b;
        use_rs2 = 1'b1;
        use_rd  = 1'b0;
        case (funct3)
          3'b000:  opcode = OP_BEQ;
          3'b001:  opcode = OP_BNE;
          3'b100:  opcode = OP_BLT;
          3'b101:  opcode = OP_BGE;
          3'b110:  opcode = OP_BLTU;
          3'b111:  opcode = OP_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      MAJ_LOAD: begin
        imm = imm_i;
        case (funct3)
          3'b000:  opcode = OP_LB;
          3'b001:  opcode = OP_LH;
          3'b010:  opcode = OP_LW;
          3'b100:  opcode = OP_LBU;
          3'b101:  opcode = OP_LHU;
          default: illegal = 1'b1;
        endcase
      end
      MAJ_STORE: begin
        imm     = imm_s;
        use_rs2 = 1'b1;
        use_rd  = 1'b0;
        case (funct3)
          3'b000:  opcode = OP_SB;
          3'b001:  opcode = OP_SH;
          3'b010:  opcode = OP_SW;
          default: illegal = 1'b1;
        endcase
      end
      MAJ_OP_IMM: begin
        imm = imm_i;
        case (funct3)
          3'b000: opcode = OP_ADDI;
          3'b001: begin
            opcode = OP_SLLI;
            imm    = imm_sh;
          end
          3'b010: opcode = OP_SLTI;
          3'b011: opcode = OP_SLTIU;
          3'b100: opcode = OP_XORI;
          3'b101: begin
            // inst[30] distinguishes arithmetic from logical right shift
            opcode = inst_in[30] ? OP_SRAI : OP_SRLI;
            imm    = imm_sh;
          end
          3'b110: opcode = OP_ORI;
          default: opcode = OP_ANDI;
        endcase
      end
      MAJ_OP: begin
        use_rs2 = 1'b1;
        case (funct3)
          3'b000: opcode = inst_in[30] ? OP_SUB : OP_ADD;
          3'b001: opcode = OP_SLL;
          3'b010: opcode = OP_SLT;
          3'b011: opcode = OP_SLTU;
          3'b100: opcode = OP_XOR;
          3'b101: opcode = inst_in[30] ? OP_SRA : OP_SRL;
          3'b110: opcode = OP_OR;
          default: opcode = OP_AND;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // An illegal word carries no meaningful payload
    if (illegal) begin
      opcode  = OP_NONE;
      imm     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
    end
  end

  always_comb begin
    entry_out         = '0;
    entry_out.pc      = pc_in;
    entry_out.opcode  = opcode;
    entry_out.rs1     = use_rs1 ? inst_in[19:15] : '0;
    entry_out.rs2     = use_rs2 ? inst_in[24:20] : '0;
    entry_out.rd      = use_rd  ? inst_in[11:7]  : '0;
    entry_out.imm     = imm;
    entry_out.illegal = illegal;
  end

endmodule

// File: rtl/dc_queue.sv
// ---------------------------------------------------------------------------
// dc_queue
// Buffered decode stage: decodes each accepted fetch word and holds the
// record in a DEPTH-entry FIFO until the dispatcher pops it.
//   clk_in   : system clock
//   rst_in   : asynchronous active-low reset, empties the queue
//   rdy_in   : when low, pointers, count and storage hold
//   flush_in : discards every buffered entry on the next edge
//   bus      : dc_queue_if.master (fetch offer/full, dispatcher pop/head)
// The head record is read combinationally from registered storage; valid
// and full are decoded straight from the count register.
// ---------------------------------------------------------------------------
module dc_queue
  import dc_pkg::*;
#(
  parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
  parameter int REG_WIDTH  = DC_REG_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  dc_queue_if.master    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  entry_t dec_entry;
  entry_t head_entry;
  logic   full, empty, push, pop;

  rv32i_decode u_decode (
    .pc_in     (DC_ADDR_WIDTH'(bus.IF2DC_pc)),
    .inst_in   (bus.IF2DC_inst),
    .entry_out (dec_entry)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // A pop in the same cycle never frees room for a push while full
  assign push  = bus.IF2DC_en && !full && !flush_in && rdy_in;
  assign pop   = bus.DP2DC_query_inst && !empty && !flush_in && rdy_in;

  // Next-state: flush wins over everything but reset; otherwise push writes
  // at tail and pop retires head, with count tracking the net change.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = dec_entry;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Head view is blanked while empty so the dispatcher sees clean zeros
  assign head_entry = mem_q[head_q];

  assign bus.DC2DP_en      = !empty;
  assign bus.DC2IF_full    = full;
  assign bus.DC2DP_pc      = empty ? '0 : ADDR_WIDTH'(head_entry.pc);
  assign bus.DC2DP_opcode  = empty ? '0 : head_entry.opcode;
  assign bus.DC2DP_rs1     = empty ? '0 : REG_WIDTH'(head_entry.rs1);
  assign bus.DC2DP_rs2     = empty ? '0 : REG_WIDTH'(head_entry.rs2);
  assign bus.DC2DP_rd      = empty ? '0 : REG_WIDTH'(head_entry.rd);
  assign bus.DC2DP_imm     = empty ? '0 : head_entry.imm;
  assign bus.DC2DP_illegal = empty ? 1'b0 : head_entry.illegal;

endmodule
